soc_sysid_checker: RTL and testbench

Boot-time sequencer that reads the system ID and timestamp words from the SoC sysid Avalon-MM slave, compares them against compile-time expected values, and reports pass/fail to the reset/boot controller. It sits between the boot controller (start/status handshake) and the sysid control slave (Avalon-MM read master). It retries stalled reads, times out, and holds its result until the next start.

---
 rtl/soc_sysid_checker_if.sv | 21 ++
 rtl/soc_sysid_checker.sv | 143 ++++++++++++++
 tb/tb_soc_sysid_checker.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_sysid_checker_if.sv
// Avalon-MM read channel between the sysid checker (master) and the sysid slave.
interface soc_sysid_checker_if;
  logic        sid_address;
  logic        sid_read;
  logic        sid_waitrequest;
  logic [31:0] sid_readdata;

  modport master (
    output sid_address,
    output sid_read,
    input  sid_waitrequest,
    input  sid_readdata
  );

  modport slave (
    input  sid_address,
    input  sid_read,
    output sid_waitrequest,
    output sid_readdata
  );
endinterface

// File: rtl/soc_sysid_checker.sv
// Boot-time sysid/timestamp checker with stall timeout and full-sequence retry.
// Timestamp read and check are enabled by defining SOC_SYSID_CHECK_TS_EN.
module soc_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS = 32'd1668928455,
  parameter int          TIMEOUT     = 16,
  parameter int          MAX_RETRY   = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  soc_sysid_checker_if.master        sid,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [1:0]                 err_code,
  output logic [31:0]                id_value,
  output logic [31:0]                ts_value
);

`ifdef SOC_SYSID_CHECK_TS_EN
  localparam logic TS_CHECK_EN = 1'b1;
`else
  localparam logic TS_CHECK_EN = 1'b0;
`endif

  localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);
  localparam logic [2:0] RETRY_MAX  = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    CMP,
    RETRY,
    DONE
  } state_t;

  state_t     state_reg;
  logic [7:0] stall_cnt_reg;
  logic [2:0] retry_cnt_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= IDLE;
      stall_cnt_reg   <= '0;
      retry_cnt_reg   <= '0;
      sid.sid_read    <= 1'b0;
      sid.sid_address <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_code        <= 2'b00;
      id_value        <= '0;
      ts_value        <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg       <= RD_ID;
            sid.sid_read    <= 1'b1;
            sid.sid_address <= 1'b0;
            busy            <= 1'b1;
            pass            <= 1'b0;
            err_code        <= 2'b00;
            retry_cnt_reg   <= '0;
            stall_cnt_reg   <= '0;
          end
        end

        RD_ID, RD_TS: begin
          if (!sid.sid_waitrequest) begin
            stall_cnt_reg <= '0;
            if (state_reg == RD_ID) begin
              id_value <= sid.sid_readdata;
              if (TS_CHECK_EN) begin
                state_reg       <= RD_TS;
                sid.sid_address <= 1'b1;
              end else begin
                state_reg    <= CMP;
                sid.sid_read <= 1'b0;
              end
            end else begin
              ts_value        <= sid.sid_readdata;
              state_reg       <= CMP;
              sid.sid_read    <= 1'b0;
              sid.sid_address <= 1'b0;
            end
          end else if (stall_cnt_reg == STALL_LAST) begin
            // This is the TIMEOUT-th stalled cycle: abort without capturing.
            stall_cnt_reg   <= '0;
            sid.sid_read    <= 1'b0;
            sid.sid_address <= 1'b0;
            if (retry_cnt_reg < RETRY_MAX) begin
              retry_cnt_reg <= retry_cnt_reg + 3'd1;
              state_reg     <= RETRY;
            end else begin
              err_code  <= 2'b11;
              pass      <= 1'b0;
              done      <= 1'b1;
              state_reg <= DONE;
            end
          end else begin
            stall_cnt_reg <= stall_cnt_reg + 8'd1;
          end
        end

        RETRY: begin
          stall_cnt_reg   <= '0;
          sid.sid_read    <= 1'b1;
          sid.sid_address <= 1'b0;
          state_reg       <= RD_ID;
        end

        CMP: begin
          if (id_value != EXPECTED_ID) begin
            err_code <= 2'b01;
          end else if (TS_CHECK_EN && (ts_value != EXPECTED_TS)) begin
            err_code <= 2'b10;
          end else begin
            pass     <= 1'b1;
            err_code <= 2'b00;
          end
          done      <= 1'b1;
          state_reg <= DONE;
        end

        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg    <= IDLE;
          sid.sid_read <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_sysid_checker.sv
// Directed bench for soc_sysid_checker: nominal, mismatch, stall, timeout/retry,
// mid-run reset and back-to-back starts. Honours SOC_SYSID_CHECK_TS_EN.
module tb_soc_sysid_checker;

`ifdef SOC_SYSID_CHECK_TS_EN
  localparam int   LAT   = 4;
  localparam logic TS_ON = 1'b1;
`else
  localparam int   LAT   = 3;
  localparam logic TS_ON = 1'b0;
`endif

  localparam logic [31:0] EXP_TS = 32'd1668928455;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: default parameters, behavioural zero/finite-wait slave
  logic        start_a = 1'b0;
  logic        busy_a, done_a, pass_a;
  logic [1:0]  err_a;
  logic [31:0] id_a, ts_a;
  logic [31:0] id_word_a = 32'h0;
  logic [31:0] ts_word_a = EXP_TS;
  int          stall_left_a = 0;
  soc_sysid_checker_if bus_a ();
  assign bus_a.sid_readdata = bus_a.sid_address ? ts_word_a : id_word_a;

  soc_sysid_checker dut_a (
    .clock    (clk),
    .reset    (rst),
    .start    (start_a),
    .sid      (bus_a),
    .busy     (busy_a),
    .done     (done_a),
    .pass     (pass_a),
    .err_code (err_a),
    .id_value (id_a),
    .ts_value (ts_a)
  );

  // DUT B: short timeout, slave permanently stalled
  logic        start_b = 1'b0;
  logic        busy_b, done_b, pass_b;
  logic [1:0]  err_b;
  logic [31:0] id_b, ts_b;
  soc_sysid_checker_if bus_b ();
  assign bus_b.sid_readdata = 32'h0;

  soc_sysid_checker #(.TIMEOUT(4), .MAX_RETRY(2)) dut_b (
    .clock    (clk),
    .reset    (rst),
    .start    (start_b),
    .sid      (bus_b),
    .busy     (busy_b),
    .done     (done_b),
    .pass     (pass_b),
    .err_code (err_b),
    .id_value (id_b),
    .ts_value (ts_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sample/drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    bus_a.sid_waitrequest = bus_a.sid_read && (stall_left_a > 0);
    if (bus_a.sid_waitrequest) stall_left_a--;
  endtask

  // Pulse start on DUT A and return the cycle number in which done is seen.
  task automatic run_a(input int stall, output int done_cyc, output logic busy1,
                       output logic addr1);
    stall_left_a = stall;
    done_cyc     = -1;
    busy1        = 1'b0;
    addr1        = 1'b0;
    start_a      = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 1) begin
        start_a = 1'b0;
        busy1   = busy_a;
      end
      if (bus_a.sid_read && bus_a.sid_address) addr1 = 1'b1;
      if (done_a) begin
        done_cyc = c;
        break;
      end
    end
    $display("txn run_a stall=%0d done_cyc=%0d pass=%0b err=%0b id=%0h ts=%0h",
             stall, done_cyc, pass_a, err_a, id_a, ts_a);
  endtask

  initial begin
    int   dc, d1, d2, attempts, gaps, rst_cyc;
    logic b1, a1, prev_rd;

    bus_a.sid_waitrequest = 1'b0;
    bus_b.sid_waitrequest = 1'b1;

    // Reset state
    repeat (3) step();
    check("rst_read_a", 32'(bus_a.sid_read), 32'd0);
    check("rst_addr_a", 32'(bus_a.sid_address), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_pass_a", 32'(pass_a), 32'd0);
    check("rst_err_a", 32'(err_a), 32'd0);
    check("rst_id_a", id_a, 32'd0);
    check("rst_ts_a", ts_a, 32'd0);
    check("rst_read_b", 32'(bus_b.sid_read), 32'd0);
    rst = 1'b0;
    step();

    // Nominal zero-wait check
    run_a(0, dc, b1, a1);
    check("nom_latency", 32'(dc), 32'(LAT));
    check("nom_busy_c1", 32'(b1), 32'd1);
    check("nom_addr1_seen", 32'(a1), 32'(TS_ON));
    check("nom_pass", 32'(pass_a), 32'd1);
    check("nom_err", 32'(err_a), 32'd0);
    check("nom_id", id_a, 32'd0);
    check("nom_ts", ts_a, TS_ON ? EXP_TS : 32'd0);
    step();
    check("nom_done_pulse", 32'(done_a), 32'd0);
    check("nom_busy_after", 32'(busy_a), 32'd0);
    check("nom_pass_held", 32'(pass_a), 32'd1);

    // ID mismatch
    id_word_a = 32'h1;
    run_a(0, dc, b1, a1);
    check("idmm_latency", 32'(dc), 32'(LAT));
    check("idmm_pass", 32'(pass_a), 32'd0);
    check("idmm_err", 32'(err_a), 32'd1);
    check("idmm_id", id_a, 32'd1);
    step();

`ifdef SOC_SYSID_CHECK_TS_EN
    // Timestamp mismatch
    id_word_a = 32'h0;
    ts_word_a = EXP_TS + 32'd1;
    run_a(0, dc, b1, a1);
    check("tsmm_err", 32'(err_a), 32'd2);
    check("tsmm_pass", 32'(pass_a), 32'd0);
    step();
`endif

    // Five stalled cycles on the ID read, well under the timeout
    id_word_a = 32'h0;
    ts_word_a = EXP_TS;
    run_a(5, dc, b1, a1);
    check("stall_latency", 32'(dc), 32'(LAT + 5));
    check("stall_pass", 32'(pass_a), 32'd1);
    check("stall_err", 32'(err_a), 32'd0);
    step();

    // Timeout with retries on DUT B: 3 attempts x 4 cycles + 2 retry gaps
    attempts = 0;
    gaps     = 0;
    dc       = -1;
    prev_rd  = 1'b0;
    start_b  = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (c == 1) start_b = 1'b0;
      if (bus_b.sid_read && !prev_rd) attempts++;
      if (!bus_b.sid_read && busy_b && !done_b) gaps++;
      prev_rd = bus_b.sid_read;
      if (done_b) begin
        dc = c;
        break;
      end
    end
    $display("txn timeout done_cyc=%0d attempts=%0d gaps=%0d err=%0b", dc, attempts, gaps, err_b);
    check("to_done_cyc", 32'(dc), 32'd15);
    check("to_attempts", 32'(attempts), 32'd3);
    check("to_gaps", 32'(gaps), 32'd2);
    check("to_err", 32'(err_b), 32'd3);
    check("to_pass", 32'(pass_b), 32'd0);
    step();
    check("to_busy_after", 32'(busy_b), 32'd0);

    // Reset during the last read of the sequence (RD_TS, or RD_ID without TS)
    id_word_a = 32'h1234;
    rst_cyc   = LAT - 2;
    start_a   = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 2; c <= rst_cyc; c++) step();
    check("mid_read_before", 32'(bus_a.sid_read), 32'd1);
    check("mid_addr_before", 32'(bus_a.sid_address), 32'(TS_ON));
    rst = 1'b1;
    step();
    rst = 1'b0;
    $display("txn mid_reset read=%0b busy=%0b id=%0h", bus_a.sid_read, busy_a, id_a);
    check("mid_read", 32'(bus_a.sid_read), 32'd0);
    check("mid_busy", 32'(busy_a), 32'd0);
    check("mid_addr", 32'(bus_a.sid_address), 32'd0);
    check("mid_id", id_a, 32'd0);
    check("mid_ts", ts_a, 32'd0);
    check("mid_pass", 32'(pass_a), 32'd0);
    check("mid_err", 32'(err_a), 32'd0);
    id_word_a = 32'h0;
    run_a(0, dc, b1, a1);
    check("post_rst_latency", 32'(dc), 32'(LAT));
    check("post_rst_pass", 32'(pass_a), 32'd1);
    step();

    // start held high for 10 cycles: back-to-back checks
    d1      = -1;
    d2      = -1;
    a1      = 1'b0;
    start_a = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (c == 10) start_a = 1'b0;
      if (bus_a.sid_read && bus_a.sid_address) a1 = 1'b1;
      if (done_a) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (c > 10 && !busy_a && d2 >= 0) break;
    end
    $display("txn back_to_back done1=%0d done2=%0d", d1, d2);
    check("b2b_first", 32'(d1), 32'(LAT));
    check("b2b_spacing", 32'(d2 - d1), 32'(LAT + 1));
    check("b2b_addr1_seen", 32'(a1), 32'(TS_ON));
    check("b2b_idle", 32'(busy_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
